// File: rtl/regfile_fwd_pkg.sv
//==============================================================================
// regfile_fwd_pkg : constants shared by the forwarding register file.
// Revision: 1.0
//==============================================================================
`default_nettype none

package regfile_fwd_pkg;

  localparam int          REG_BUS_W      = 32;
  localparam int          REG_ADDR_BUS_W = 5;
  localparam int          REG_NUM        = 32;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic        READ_ENABLE    = 1'b1;
  localparam logic        WRITE_ENABLE   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile_rd_sel.sv
//==============================================================================
// regfile_rd_sel : priority read selection and load-hit flag for one read port.
// Revision: 1.0
//==============================================================================
`default_nettype none

module regfile_rd_sel
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_ld,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         arr_data,
  output logic [DATA_W-1:0]         data,
  output logic                      ld_hit
);

  logic fwd_hit;

  always_comb begin
    data    = '0;
    ld_hit  = 1'b0;
    fwd_hit = 1'b0;
    // Walk oldest to youngest so the lowest matching index is the one that sticks.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_addr[i*ADDR_W +: ADDR_W] == raddr)) begin
        fwd_hit = 1'b1;
        data    = fwd_data[i*DATA_W +: DATA_W];
        ld_hit  = fwd_ld[i];
      end
    end
    if (!fwd_hit) begin
      data = ((we == WRITE_ENABLE) && (waddr == raddr)) ? wdata : arr_data;
    end
    if ((re != READ_ENABLE) || (raddr == '0)) begin
      data   = '0;
      ld_hit = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_fwd.sv
//==============================================================================
// regfile_fwd : GPR file with WB write-through, multi-source forwarding and load-use stall.
// Revision: 1.0
//==============================================================================
`default_nettype none

module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_RD  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_ld,
  input  logic [NUM_RD-1:0]         re,
  input  logic [NUM_RD*ADDR_W-1:0]  raddr,
  input  logic                      hold,
  output logic [NUM_RD*DATA_W-1:0]  rdata,
  output logic                      stall_req
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] sel;
  logic [NUM_RD-1:0]        ld_hit;

  // Entry 0 is never written, so its reset value keeps it hardwired to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if ((we == WRITE_ENABLE) && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    regfile_rd_sel #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_FWD (NUM_FWD)
    ) u_rd_sel (
      .re       (re[p]),
      .raddr    (raddr[p*ADDR_W +: ADDR_W]),
      .fwd_we   (fwd_we),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data),
      .fwd_ld   (fwd_ld),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .arr_data (mem[raddr[p*ADDR_W +: ADDR_W]]),
      .data     (sel[p*DATA_W +: DATA_W]),
      .ld_hit   (ld_hit[p])
    );
  end

  assign stall_req = rst && (|ld_hit);

  if (REG_RD != 0) begin : g_reg_rd
    logic [NUM_RD*DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q <= '0;
      end else if (!hold) begin
        rdata_q <= sel;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb_rd
    logic unused_hold;

    assign unused_hold = hold;
    // Forwarded data is masked too, so the port reads zero throughout reset.
    assign rdata       = rst ? sel : '0;
  end

endmodule

`default_nettype wire
